// File: rtl/vec_ew_alu.sv
// vec_ew_alu: multi-cycle element-wise vector ALU (ADD, SUB, signed MAX, signed MIN).
// Each vector is processed LANES elements per clock over NUM_BEATS beats.
// A sticky flag reports signed overflow in any ADD/SUB lane of the vector.
// Build option: define VEC_EW_ALU_SATURATE_EN to clamp overflowing ADD/SUB lanes
// instead of wrapping them. The default build wraps.

`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 64
`endif

`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 16
`endif

module vec_ew_alu #(
  parameter int VEC_LEN    = `MAX_EMBEDDING_DIM,
  parameter int DATA_WIDTH = `INTEGER_WIDTH,
  parameter int LANES      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vld_in,
  output logic                          rdy_out,
  input  logic [1:0]                    mode_in,
  input  logic [DATA_WIDTH*VEC_LEN-1:0] a_in,
  input  logic [DATA_WIDTH*VEC_LEN-1:0] b_in,
  output logic                          vld_out,
  input  logic                          rdy_in,
  output logic [DATA_WIDTH*VEC_LEN-1:0] result,
  output logic                          ovf_out
);

  localparam int NUM_BEATS = VEC_LEN / LANES;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int VEC_W     = DATA_WIDTH * VEC_LEN;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

`ifdef VEC_EW_ALU_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  // The beat schedule only works when the vector splits evenly into lanes.
  generate
    if ((LANES < 1) || (VEC_LEN % LANES != 0)) begin : g_badLanes
      $error("vec_ew_alu: VEC_LEN (%0d) must be a non-zero multiple of LANES (%0d)", VEC_LEN, LANES);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [VEC_W-1:0]        opA_q, opA_d;
  logic [VEC_W-1:0]        opB_q, opB_d;
  logic [1:0]              mode_q, mode_d;
  logic [VEC_W-1:0]        result_q, result_d;
  logic                    ovf_q, ovf_d;

  logic                    accept;

  logic [DATA_WIDTH-1:0]   laneA   [LANES];
  logic [DATA_WIDTH-1:0]   laneB   [LANES];
  logic [DATA_WIDTH:0]     laneSum [LANES];
  logic [DATA_WIDTH-1:0]   laneRes [LANES];
  logic [LANES-1:0]        laneOvf;

  assign accept = vld_in && rdy_out;

  // State register: the handshake FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE can hand straight back to BUSY for back-to-back vectors.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        if (beat_q == LAST_BEAT) state_d = DONE;
      end
      DONE: begin
        if (rdy_in) state_d = vld_in ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs: ready when idle, or when the finished result is being taken.
  always_comb begin
    rdy_out = (state_q == IDLE) || ((state_q == DONE) && rdy_in);
    vld_out = (state_q == DONE);
  end

  // Route the operand slice for the current beat onto the shared lane ALUs.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      laneA[l] = '0;
      laneB[l] = '0;
      for (int b = 0; b < NUM_BEATS; b++) begin
        if (beat_q == BEAT_W'(b)) begin
          laneA[l] = opA_q[(b*LANES + l)*DATA_WIDTH +: DATA_WIDTH];
          laneB[l] = opB_q[(b*LANES + l)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Lane ALUs: one extra bit on ADD/SUB exposes signed overflow; MAX/MIN keep a on ties.
  always_comb begin
    laneOvf = '0;
    for (int l = 0; l < LANES; l++) begin
      if (mode_q[0]) begin
        laneSum[l] = {laneA[l][DATA_WIDTH-1], laneA[l]} - {laneB[l][DATA_WIDTH-1], laneB[l]};
      end else begin
        laneSum[l] = {laneA[l][DATA_WIDTH-1], laneA[l]} + {laneB[l][DATA_WIDTH-1], laneB[l]};
      end
      laneRes[l] = laneA[l];
      if (!mode_q[1]) begin
        laneOvf[l] = laneSum[l][DATA_WIDTH] ^ laneSum[l][DATA_WIDTH-1];
        laneRes[l] = laneSum[l][DATA_WIDTH-1:0];
`ifdef VEC_EW_ALU_SATURATE_EN
        if (laneOvf[l]) begin
          laneRes[l] = laneSum[l][DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end
`endif
      end else if (mode_q[0]) begin
        if ($signed(laneA[l]) > $signed(laneB[l])) laneRes[l] = laneB[l];
      end else begin
        if ($signed(laneA[l]) < $signed(laneB[l])) laneRes[l] = laneB[l];
      end
    end
  end

  // Datapath next state: capture on accept, otherwise write one beat of lanes while BUSY.
  always_comb begin
    opA_d    = opA_q;
    opB_d    = opB_q;
    mode_d   = mode_q;
    beat_d   = beat_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (accept) begin
      opA_d  = a_in;
      opB_d  = b_in;
      mode_d = mode_in;
      beat_d = '0;
      ovf_d  = 1'b0;
    end else if (state_q == BUSY) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
      ovf_d  = ovf_q | (|laneOvf);
      for (int b = 0; b < NUM_BEATS; b++) begin
        if (beat_q == BEAT_W'(b)) begin
          for (int l = 0; l < LANES; l++) begin
            result_d[(b*LANES + l)*DATA_WIDTH +: DATA_WIDTH] = laneRes[l];
          end
        end
      end
    end
  end

  // Datapath registers: everything clears asynchronously so an aborted vector leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opA_q    <= '0;
      opB_q    <= '0;
      mode_q   <= '0;
      beat_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      mode_q   <= mode_d;
      beat_q   <= beat_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result  = result_q;
  assign ovf_out = ovf_q;

endmodule

// File: tb/tb_vec_ew_alu.sv
// tb_vec_ew_alu: self-checking bench for vec_ew_alu (VEC_LEN=8, LANES=2, DATA_WIDTH=8).
// Follows VEC_EW_ALU_SATURATE_EN so the same bench covers both builds.

module tb_vec_ew_alu;

  localparam int VL = 8;
  localparam int LN = 2;
  localparam int DW = 8;
  localparam int VW = VL * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          vld_in;
  logic          rdy_out;
  logic [1:0]    mode_in;
  logic [VW-1:0] a_in;
  logic [VW-1:0] b_in;
  logic          vld_out;
  logic          rdy_in;
  logic [VW-1:0] result;
  logic          ovf_out;

  int assertCount = 0;
  int failCount   = 0;

  logic [VW-1:0] sbRes[$];
  logic          sbOvf[$];
  logic [VW-1:0] monExpR;
  logic          monExpO;
  logic [VW-1:0] monModR;
  logic          monModO;

  vec_ew_alu #(
    .VEC_LEN   (VL),
    .DATA_WIDTH(DW),
    .LANES     (LN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .vld_in (vld_in),
    .rdy_out(rdy_out),
    .mode_in(mode_in),
    .a_in   (a_in),
    .b_in   (b_in),
    .vld_out(vld_out),
    .rdy_in (rdy_in),
    .result (result),
    .ovf_out(ovf_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [VW-1:0] actual, input logic [VW-1:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Golden model in plain integer arithmetic.
  function automatic void goldenModel(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [1:0] m,
                                      output logic [VW-1:0] r, output logic o);
    int x;
    int y;
    int s;
    r = '0;
    o = 1'b0;
    for (int i = 0; i < VL; i++) begin
      x = int'($signed(a[i*DW +: DW]));
      y = int'($signed(b[i*DW +: DW]));
      case (m)
        2'd0:    s = x + y;
        2'd1:    s = x - y;
        2'd2:    s = (x >= y) ? x : y;
        default: s = (x <= y) ? x : y;
      endcase
      if (m < 2'd2 && (s > 127 || s < -128)) begin
        o = 1'b1;
`ifdef VEC_EW_ALU_SATURATE_EN
        s = (s > 127) ? 127 : -128;
`endif
      end
      r[i*DW +: DW] = DW'(s);
    end
  endfunction

  function automatic logic [VW-1:0] packVec(input int e [VL]);
    logic [VW-1:0] v;
    for (int i = 0; i < VL; i++) v[i*DW +: DW] = DW'(e[i]);
    return v;
  endfunction

  // Scoreboard monitor: samples handshakes just before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        if (vld_out && rdy_in) begin
          if (sbRes.size() == 0) begin
            checkOutput("sbUnderflow", VW'(vld_out), '0);
          end else begin
            monExpR = sbRes.pop_front();
            monExpO = sbOvf.pop_front();
            checkOutput("sbResult", result, monExpR);
            checkOutput("sbOvf", VW'(ovf_out), VW'(monExpO));
          end
        end
        if (vld_in && rdy_out) begin
          goldenModel(a_in, b_in, mode_in, monModR, monModO);
          sbRes.push_back(monModR);
          sbOvf.push_back(monModO);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge right after the accept edge.
  task automatic applyStimulus(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [1:0] m);
    int waitCycles;
    waitCycles = 0;
    a_in    = a;
    b_in    = b;
    mode_in = m;
    vld_in  = 1'b1;
    #4;
    while (!rdy_out && waitCycles < 50) begin
      @(negedge clk);
      #4;
      waitCycles++;
    end
    if (waitCycles >= 50) checkOutput("acceptTimeout", VW'(rdy_out), VW'(1));
    @(negedge clk);
    vld_in = 1'b0;
  endtask

  task automatic waitResult(input string tag, input logic [VW-1:0] expR, input logic expO);
    int edges;
    edges = 0;
    while (!vld_out && edges < 20) begin
      checkOutput({tag, "RdyBusy"}, VW'(rdy_out), '0);
      @(negedge clk);
      edges++;
    end
    checkOutput({tag, "Latency"}, VW'(edges), VW'(4));
    checkOutput({tag, "Result"}, result, expR);
    checkOutput({tag, "Ovf"}, VW'(ovf_out), VW'(expO));
  endtask

  task automatic runDirected(input string tag, input logic [VW-1:0] a, input logic [VW-1:0] b,
                             input logic [1:0] m, input logic [VW-1:0] expR, input logic expO);
    rdy_in = 1'b1;
    applyStimulus(a, b, m);
    waitResult(tag, expR, expO);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [VW-1:0] addA, addB, addR, zero, ovA, ovB, ovR, mmA, mmB, maxR, minR;
    int ea [VL];
    int sent;
    int cyc;
    logic justAccepted;

    rst     = 1'b1;
    vld_in  = 1'b0;
    rdy_in  = 1'b0;
    mode_in = 2'd0;
    a_in    = '0;
    b_in    = '0;
    zero    = '0;

    for (int i = 0; i < VL; i++) begin
      addA[i*DW +: DW] = DW'(i + 1);
      addB[i*DW +: DW] = DW'(10);
      addR[i*DW +: DW] = DW'(i + 11);
    end
    ea = '{-5, 3, 7, -128, 0, 1, 2, 3};      mmA  = packVec(ea);
    ea = '{4, 3, -7, 127, 0, -1, 2, -3};     mmB  = packVec(ea);
    ea = '{4, 3, 7, 127, 0, 1, 2, 3};        maxR = packVec(ea);
    ea = '{-5, 3, -7, -128, 0, -1, 2, -3};   minR = packVec(ea);

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstVld", VW'(vld_out), '0);
    checkOutput("rstResult", result, '0);
    checkOutput("rstOvf", VW'(ovf_out), '0);
    checkOutput("rstRdy", VW'(rdy_out), VW'(1));
    rst = 1'b0;
    @(negedge clk);

    // Basic ADD
    runDirected("add", addA, addB, 2'd0, addR, 1'b0);

    // Reset two edges into BUSY
    applyStimulus(addA, addB, 2'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstVld", VW'(vld_out), '0);
    checkOutput("midRstResult", result, '0);
    checkOutput("midRstOvf", VW'(ovf_out), '0);
    sbRes.delete();
    sbOvf.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstRdy", VW'(rdy_out), VW'(1));
    checkOutput("postRstVld", VW'(vld_out), '0);

    // ADD overflow in lane 3
    ovA = '0; ovB = '0; ovR = '0;
    ovA[3*DW +: DW] = 8'd100;
    ovB[3*DW +: DW] = 8'd100;
`ifdef VEC_EW_ALU_SATURATE_EN
    ovR[3*DW +: DW] = 8'h7F;
`else
    ovR[3*DW +: DW] = 8'hC8;
`endif
    runDirected("addOvf", ovA, ovB, 2'd0, ovR, 1'b1);

    // SUB overflow in lane 0
    ovA = '0; ovB = '0; ovR = '0;
    ovA[0 +: DW] = 8'h9C;
    ovB[0 +: DW] = 8'd100;
`ifdef VEC_EW_ALU_SATURATE_EN
    ovR[0 +: DW] = 8'h80;
`else
    ovR[0 +: DW] = 8'h38;
`endif
    runDirected("subOvf", ovA, ovB, 2'd1, ovR, 1'b1);

    // Signed MAX / MIN, including the extremes and ties
    runDirected("max", mmA, mmB, 2'd2, maxR, 1'b0);
    runDirected("min", mmA, mmB, 2'd3, minR, 1'b0);

    // Backpressure: let the previous result drain, then hold the next one in DONE
    @(negedge clk);
    rdy_in = 1'b0;
    applyStimulus(addA, addB, 2'd0);
    waitResult("bp1", addR, 1'b0);
    a_in    = mmA;
    b_in    = mmB;
    mode_in = 2'd2;
    vld_in  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #4;
      checkOutput("bpResult", result, addR);
      checkOutput("bpOvf", VW'(ovf_out), '0);
      checkOutput("bpRdy", VW'(rdy_out), '0);
      checkOutput("bpVld", VW'(vld_out), VW'(1));
      @(negedge clk);
    end
    rdy_in = 1'b1;
    #4;
    checkOutput("bpRdyRelease", VW'(rdy_out), VW'(1));
    @(negedge clk);
    vld_in = 1'b0;
    checkOutput("bpNoBubbleVld", VW'(vld_out), '0);
    waitResult("bp2", maxR, 1'b0);

    // Random traffic through the scoreboard
    sent = 0;
    cyc = 0;
    justAccepted = 1'b0;
    while (sent < 200 && cyc < 20000) begin
      @(negedge clk);
      if (justAccepted) vld_in = 1'b0;
      rdy_in = ($urandom_range(0, 3) != 0);
      if (!vld_in && $urandom_range(0, 2) != 0) begin
        for (int i = 0; i < VL; i++) begin
          a_in[i*DW +: DW] = DW'($urandom);
          b_in[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? a_in[i*DW +: DW] : DW'($urandom);
        end
        mode_in = 2'($urandom_range(0, 3));
        vld_in  = 1'b1;
      end
      #4;
      justAccepted = vld_in && rdy_out;
      if (justAccepted) sent++;
      cyc++;
    end
    if (sent < 200) checkOutput("randSent", VW'(sent), VW'(200));
    @(negedge clk);
    vld_in = 1'b0;
    rdy_in = 1'b1;
    cyc = 0;
    while (sbRes.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("sbDrain", VW'(sbRes.size()), zero);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/vec_ew_alu.md
Name: vec_ew_alu

Overview:
- Parametrised, multi-cycle element-wise vector ALU. Successor to the single-mode vector adder.
- Computes ADD, SUB, signed MAX or signed MIN over two VEC_LEN vectors, LANES elements per cycle.
- Trades area for latency in the attention datapath (score/accumulator updates, running-max).
- Adds a per-vector signed-overflow flag; saturation is an optional build feature.

Parameters:
- VEC_LEN, `MAX_EMBEDDING_DIM, elements per vector
- DATA_WIDTH, `INTEGER_WIDTH, bits per element; two's-complement signed
- LANES, 4, elements processed per cycle; VEC_LEN % LANES == 0 (elaboration-time $error otherwise)
- Derived: NUM_BEATS = VEC_LEN/LANES; BEAT_W = max(1, $clog2(NUM_BEATS))

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- vld_in  in  1  upstream valid
- rdy_out  out  1  ready to upstream
- mode_in  in  2  00 ADD, 01 SUB (a-b), 10 MAX, 11 MIN; sampled with the operands
- a_in  in  DATA_WIDTH x VEC_LEN  operand A
- b_in  in  DATA_WIDTH x VEC_LEN  operand B
- vld_out  out  1  result valid
- rdy_in  in  1  downstream ready
- result  out  DATA_WIDTH x VEC_LEN  element-wise result, registered
- ovf_out  out  1  any lane overflowed (ADD/SUB only); qualified by vld_out

Behaviour:
- Reset (async assert, any state): state=IDLE, beat counter=0, operand/mode regs=0, result=all 0, ovf_out=0, vld_out=0.
- States: IDLE, BUSY, DONE.
- rdy_out = (state==IDLE) || (state==DONE && rdy_in). It is combinational from state and rdy_in. It is 0 in BUSY.
- Accept: vld_in && rdy_out at a clk edge.
  - Latch a_in, b_in and mode_in.
  - Clear beat=0 and the ovf accumulator.
  - Go to BUSY.
- IDLE: on accept go to BUSY; otherwise hold.
- BUSY: each edge computes lanes [beat*LANES, beat*LANES+LANES-1] into result and ORs the lane overflows into ovf.
  - beat increments each edge.
  - When beat==NUM_BEATS-1, beat wraps to 0 and the state goes to DONE.
  - rdy_in is ignored in BUSY.
- DONE: vld_out=1. result and ovf_out are held stable while rdy_in=0.
  - If rdy_in && vld_in: accept the new vector and go straight to BUSY, giving back-to-back operation.
  - If rdy_in && !vld_in: go to IDLE.
- Latency: vld_out rises NUM_BEATS edges after the accept edge. Throughput: one vector per NUM_BEATS+1 cycles.
- vld_out = (state==DONE).
- result lanes not yet rewritten in BUSY hold their previous values. They are not meaningful until vld_out.
- Arithmetic: full signed DATA_WIDTH+1-bit sum/difference.
  - Lane overflow = the result does not fit in signed DATA_WIDTH.
  - Default output is the wrapped low DATA_WIDTH bits.
- MAX/MIN use signed compare, never overflow, and tie returns a.
- NUM_BEATS==1: BUSY lasts one edge. The counter is unused and must not cause width errors.
- Deassertion of rst is synchronised externally; the block needs no extra handling.

Optional Feature:
- Macro: VEC_EW_ALU_SATURATE_EN.
- Defined: ADD/SUB lanes that overflow clamp to +2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1). ovf_out still reports that a clamp occurred.
- Undefined: two's-complement wrap. ovf_out still reports the overflow.
- MAX/MIN are unaffected in both builds.

Test Plan (VEC_LEN=8, LANES=2, DATA_WIDTH=8, NUM_BEATS=4):
- Reset mid-BUSY: assert rst two cycles after accept -> vld_out=0, result all 0, ovf_out=0 immediately; rdy_out=1 after release.
- ADD, a=1..8, b=10 each, rdy_in=1 -> vld_out rises exactly 4 edges after accept; result=11..18; ovf_out=0; rdy_out=0 during BUSY.
- Overflow: ADD a[3]=100, b[3]=100, other lanes 0 -> wrap build: result[3]=-56 (0xC8), ovf_out=1; SATURATE build: result[3]=127, ovf_out=1. SUB a[0]=-100, b[0]=100 -> -128 with saturation, 56 wrapped, ovf_out=1.
- MAX/MIN: a={-5,3,7,-128,0,1,2,3}, b={4,3,-7,127,0,-1,2,-3} -> MAX={4,3,7,127,0,1,2,3}, MIN={-5,3,-7,-128,0,-1,2,-3}; ovf_out=0.
- Backpressure: rdy_in=0 for 5 cycles in DONE with new vld_in pending -> result/ovf_out stable, rdy_out=0. rdy_in=1 -> same-edge accept, next result after 4 more edges, no bubble state.
- Random: 200 vectors, random modes, random vld_in/rdy_in -> scoreboard matches the golden model; no vector is dropped or duplicated.
